// File: rtl/rf_wr_arbiter.sv
// Round-robin owner arbiter for the single register-file write port.
// An owner keeps the port until it drops req or runs MAX_HOLD cycles; then one IDLE bubble.
module rf_wr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         wr_en,
  input  logic [N_REQ*ADDR_W-1:0]  wr_addr,
  input  logic [N_REQ*DATA_W-1:0]  wr_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     timeout
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    gnt_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [IDX_W-1:0]    pick;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                timeout_nxt;
  logic                owns;

  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [DATA_W-1:0]   data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = wr_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = wr_data[i*DATA_W +: DATA_W];
  end

  // First set request scanning upward from p, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(p) + k) % N_REQ);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign pick = rr_pick(req, ptr);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          owner_nxt     = pick;
          hold_nxt      = '0;
          state_nxt     = OWN;
        end
      end
      OWN: begin
        hold_nxt = hold_cnt + HOLD_W'(1);
        if (!req[owner] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          gnt_nxt     = '0;
          ptr_nxt     = next_idx(owner);
          state_nxt   = IDLE;
          timeout_nxt = req[owner];
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

  // Write port follows the registered owner; req gates the strobe so a dropping owner cannot write.
  assign owns    = (state == OWN);
  assign rf_we   = owns & req[owner] & wr_en[owner];
  assign rf_addr = owns ? addr_arr[owner] : '0;
  assign rf_data = owns ? data_arr[owner] : '0;

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Round-robin arbiter that shares the single register-file write port among N_REQ requesters (e.g. ALU writeback, load unit, CSR unit, debug). Requesters hold a request line and own the port until they drop it or a hold timeout forces release. The winner's address, data and write enable are muxed onto the register-file write port, and the grant is registered.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- MAX_HOLD, 8, max consecutive cycles one owner may hold the port (>=1)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  N_REQ  per-requester request; held high while port is wanted
- wr_en  input  N_REQ  per-requester write strobe, valid only while granted
- wr_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wr_data  input  N_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- gnt  output  N_REQ  registered one-hot grant (all-zero when idle)
- rf_we  output  1  register-file write enable
- rf_addr  output  ADDR_W  register-file write address
- rf_data  output  DATA_W  register-file write data
- timeout  output  1  registered one-cycle pulse when an owner is forcibly released

## Operation
- States: IDLE, OWN. Registers: state, gnt, owner index, rr pointer ptr, hold_cnt (clog2(MAX_HOLD)+1 bits), timeout.
- IDLE: if any req bit is high at the edge, select the first set bit scanning ptr, ptr+1, ... modulo N_REQ; set gnt to that one-hot, owner = index, hold_cnt = 0, go OWN. No req: stay IDLE, gnt = 0.
- OWN: hold_cnt increments each edge. Release when req[owner] is low at the edge, or when hold_cnt == MAX_HOLD-1 and req[owner] is still high (timeout). On release: gnt = 0, ptr = (owner+1) mod N_REQ, state IDLE. On timeout release also pulse timeout = 1 for the following cycle.
- Write port (combinational from registered gnt): rf_we = req[owner] & wr_en[owner] & (state==OWN). rf_addr/rf_data = owner's slice while in OWN, else 0.
- Writes while req[owner] is low are ignored even if wr_en is high. The last cycle before a timeout release still writes.
- Non-owner wr_en and request changes never affect the port.
- Address 0 is passed through. x0 suppression is the register file's job.

## Timing
- Reset (async, immediate): state IDLE, gnt 0, owner 0, ptr 0, hold_cnt 0, timeout 0. Hence rf_we 0, rf_addr 0, rf_data 0. Reset mid-ownership drops gnt and rf_we without waiting for a clock edge.
- Grant latency: req sampled high at edge E gives gnt high after E. The first write can occur in the cycle following E.
- Release: req[owner] sampled low at edge E gives gnt low after E. There is a mandatory one-cycle IDLE bubble, so the next grant is no earlier than edge E+1.
- Max ownership: MAX_HOLD cycles of gnt high, then forced IDLE for one cycle.
- If only the timed-out requester still requests, it is re-granted at the next edge after the bubble.
- Simultaneous requests: the winner is decided by ptr only. Grants never change while in OWN.
- timeout is high for exactly one cycle, the IDLE bubble after a forced release.

## Test plan
- Reset: assert rst mid-ownership, between clock edges. Required: gnt=0000, rf_we=0 and timeout=0 immediately; after deassert and req=0010, gnt=0010 after the next edge.
- Single requester: req=0100, wr_en=1, wr_addr[2]=5'd7, wr_data[2]=32'hDEAD_BEEF for 3 cycles, then drop req. Required: rf_we=1, rf_addr=7, rf_data=DEADBEEF for 3 cycles; gnt=0000 one cycle after the drop.
- Round robin: req=1111 held, each owner drops req after 1 write. Required: grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Timeout: MAX_HOLD=8, req=0011 with requester 0 never dropping. Required: gnt=0001 for exactly 8 cycles, timeout=1 for 1 cycle, then gnt=0010.
- Solo timeout: req=0001 held forever. Required: a repeating pattern of 8 cycles gnt=0001, 1 cycle gnt=0000 with timeout=1.
- Isolation: requester 1 is owner; requester 3 toggles wr_en and changes wr_addr/wr_data. Required: rf_addr/rf_data track requester 1 only; rf_we=0 whenever wr_en[1]=0.
